// File: rtl/ewh_pkg.sv
// Shared definitions for the target panel responder.
// Contents:
//   NUM_TARGETS_DEFAULT - default number of physical targets (LED + photodiode)
//   target_idx_t        - 4-bit target index type
//   state_t             - responder FSM state encoding (IDLE, ARM, ACTIVE, REPORT)
package ewh_pkg;

  localparam int NUM_TARGETS_DEFAULT = 10;

  typedef logic [3:0] target_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/hit_debouncer.sv
// Qualifies a hit once the input bit has been high on DEBOUNCE_CYCLES
// consecutive enabled cycles, and reports the count value captured on the
// first cycle of the qualifying run.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset
//   sample        - photodiode bit being watched
//   clear         - holds the run count at zero (used outside the active window)
//   count         - elapsed-cycle value to capture at the start of a run
//   qualified     - combinational pulse on the cycle the last required high sample is taken
//   run_start     - count value at the first cycle of the current run
module hit_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample,
  input  logic        clear,
  input  logic [31:0] count,
  output logic        qualified,
  output logic [31:0] run_start
);

  // run holds how many high samples preceded this cycle; it never exceeds
  // DEBOUNCE_CYCLES-1 because reaching the last sample qualifies instead.
  localparam int RW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [RW-1:0] LAST = RW'(DEBOUNCE_CYCLES - 1);

  logic [RW-1:0] run;
  logic [31:0]   start_q;

  assign qualified = !clear && sample && (run == LAST);

  // When no run is in progress the current sample is itself the run start,
  // which also covers DEBOUNCE_CYCLES == 1.
  assign run_start = (run == '0) ? count : start_q;

  always_ff @(posedge clock) begin
    if (reset || clear || !sample || qualified) begin
      run <= '0;
    end else begin
      run <= run + RW'(1);
    end

    if (reset) begin
      start_q <= '0;
    end else if (!clear && sample && (run == '0)) begin
      start_q <= count;
    end
  end

endmodule

// File: rtl/target_panel_responder.sv
// Lights one target on request, waits out a blanking period, then times how
// long it takes for that target's photodiode to register a debounced hit,
// reporting a miss after a timeout.
//
// Handshakes:
//   request: a transfer happens on a rising edge where target_valid && target_ready;
//            target_ready is high only in IDLE.
//   result:  result_valid stays high with result_* stable until result_ack is
//            seen high on a rising edge; the responder returns to IDLE next cycle.
//
// Ports:
//   clock, reset           - rising-edge clock, synchronous active-high reset
//   target_idx/valid/ready - request channel
//   cancel                 - aborts a target in ARM or ACTIVE, no result produced
//   photo_array            - raw photodiode levels, bit i = target i
//   led                    - one-hot illumination of the selected target
//   result_valid/hit/idx/time, result_ack - result channel
//   fsm_state              - current FSM state for observation
module target_panel_responder
  import ewh_pkg::*;
#(
  parameter int NUM_TARGETS     = NUM_TARGETS_DEFAULT,
  parameter int BLANK_CYCLES    = 16,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 50_000_000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  target_idx_t            target_idx,
  input  logic                   target_valid,
  output logic                   target_ready,
  input  logic                   cancel,
  input  logic [NUM_TARGETS-1:0] photo_array,
  output logic [NUM_TARGETS-1:0] led,
  output logic                   result_valid,
  output logic                   result_hit,
  output target_idx_t            result_idx,
  output logic [31:0]            result_time,
  input  logic                   result_ack,
  output state_t                 fsm_state
);

  logic [NUM_TARGETS-1:0] req_mask;
  logic [NUM_TARGETS-1:0] sel_mask;
  logic                   idx_ok;
  target_idx_t            cur_idx;
  logic [31:0]            arm_cnt;
  logic [31:0]            elapsed;
  logic                   photo_bit;
  logic                   in_active;
  logic                   hit;
  logic [31:0]            hit_start;

  assign target_ready = (fsm_state == IDLE);
  assign req_mask     = NUM_TARGETS'(1) << target_idx;
  assign idx_ok       = 32'(target_idx) < 32'(NUM_TARGETS);

  // sel_mask is kept separate from led so the watched bit is still selected
  // by mask, never by an index that could fall outside the array.
  assign photo_bit = |(photo_array & sel_mask);
  assign in_active = (fsm_state == ACTIVE);

  hit_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock     (clock),
    .reset     (reset),
    .sample    (photo_bit),
    .clear     (!in_active),
    .count     (elapsed),
    .qualified (hit),
    .run_start (hit_start)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_state    <= IDLE;
      led          <= '0;
      sel_mask     <= '0;
      cur_idx      <= '0;
      arm_cnt      <= '0;
      elapsed      <= '0;
      result_valid <= 1'b0;
      result_hit   <= 1'b0;
      result_idx   <= '0;
      result_time  <= '0;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (target_valid) begin
            if (idx_ok) begin
              fsm_state <= ARM;
              cur_idx   <= target_idx;
              sel_mask  <= req_mask;
              led       <= req_mask;
              arm_cnt   <= '0;
            end else begin
              // Out-of-range index: report an immediate invalid result.
              fsm_state    <= REPORT;
              led          <= '0;
              sel_mask     <= '0;
              result_valid <= 1'b1;
              result_hit   <= 1'b0;
              result_idx   <= target_idx;
              result_time  <= '0;
            end
          end
        end

        ARM: begin
          if (cancel) begin
            fsm_state <= IDLE;
            led       <= '0;
            sel_mask  <= '0;
            arm_cnt   <= '0;
          end else if (arm_cnt == 32'(BLANK_CYCLES - 1)) begin
            fsm_state <= ACTIVE;
            arm_cnt   <= '0;
            elapsed   <= '0;
          end else begin
            arm_cnt <= arm_cnt + 32'd1;
          end
        end

        ACTIVE: begin
          if (cancel) begin
            fsm_state <= IDLE;
            led       <= '0;
            sel_mask  <= '0;
            elapsed   <= '0;
          end else if (hit) begin
            // Checked before the timeout so a hit on the last cycle wins.
            fsm_state    <= REPORT;
            led          <= '0;
            sel_mask     <= '0;
            elapsed      <= '0;
            result_valid <= 1'b1;
            result_hit   <= 1'b1;
            result_idx   <= cur_idx;
            result_time  <= hit_start;
          end else if (elapsed == 32'(TIMEOUT_CYCLES - 1)) begin
            fsm_state    <= REPORT;
            led          <= '0;
            sel_mask     <= '0;
            elapsed      <= '0;
            result_valid <= 1'b1;
            result_hit   <= 1'b0;
            result_idx   <= cur_idx;
            result_time  <= 32'(TIMEOUT_CYCLES);
          end else begin
            elapsed <= elapsed + 32'd1;
          end
        end

        REPORT: begin
          if (result_ack) begin
            fsm_state    <= IDLE;
            result_valid <= 1'b0;
          end
        end

        default: fsm_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_target_panel_responder.sv
module tb_target_panel_responder;
  import ewh_pkg::*;

  localparam int N  = 10;
  localparam int W  = 37;  // {hit, idx[3:0], time[31:0]}

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  target_idx_t  target_idx = '0;
  logic         target_valid = 1'b0;
  logic         target_ready;
  logic         cancel = 1'b0;
  logic [N-1:0] photo_array = '0;
  logic [N-1:0] led;
  logic         result_valid;
  logic         result_hit;
  target_idx_t  result_idx;
  logic [31:0]  result_time;
  logic         result_ack = 1'b0;
  state_t       fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] cur_exp;
  logic         prev_valid = 1'b0;

  target_panel_responder #(
    .NUM_TARGETS(N), .BLANK_CYCLES(16), .DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(100)
  ) dut (
    .clock(clock), .reset(reset), .target_idx(target_idx), .target_valid(target_valid),
    .target_ready(target_ready), .cancel(cancel), .photo_array(photo_array), .led(led),
    .result_valid(result_valid), .result_hit(result_hit), .result_idx(result_idx),
    .result_time(result_time), .result_ack(result_ack), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver tasks
  task automatic send(input logic [3:0] idx);
    target_idx   = idx;
    target_valid = 1'b1;
    check("ready_in_idle", target_ready, 1);
    tick();
    target_valid = 1'b0;
  endtask

  // Runs the blanking period after a valid send; ends at ACTIVE cycle 0.
  task automatic run_arm(input int idx);
    logic [N-1:0] m;
    m = N'(1) << idx;
    check("arm_state", fsm_state, ARM);
    check("arm_led", led, m);
    repeat (15) tick();
    check("arm_last_cycle", fsm_state, ARM);
    check("arm_no_result", result_valid, 0);
    tick();
    check("active_entry", fsm_state, ACTIVE);
    check("active_led", led, m);
  endtask

  task automatic expect_result(input logic hit, input logic [3:0] idx, input logic [31:0] t);
    exp_q.push_back({hit, idx, t});
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    check("ack_to_idle", fsm_state, IDLE);
    check("ack_valid_low", result_valid, 0);
    check("ack_ready", target_ready, 1);
  endtask

  // scoreboard monitor: pops on each new result, then checks it stays put
  always @(negedge clock) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: got %0h expected none",
                   {result_hit, result_idx, result_time});
          cur_exp = {result_hit, result_idx, result_time};
        end else begin
          cur_exp = exp_q.pop_front();
          check("result_fields", {result_hit, result_idx, result_time}, cur_exp);
        end
      end else if (result_valid) begin
        check("result_stable", {result_hit, result_idx, result_time}, cur_exp);
      end
      if (result_valid) check("report_led_zero", led, 0);
      prev_valid <= result_valid;
    end
  end

  initial begin
    // reset state
    tick();
    tick();
    check("rst_state", fsm_state, IDLE);
    check("rst_led", led, 0);
    check("rst_valid", result_valid, 0);
    check("rst_fields", {result_hit, result_idx, result_time}, 0);
    reset = 1'b0;
    check("rst_ready", target_ready, 1);

    // idx 3: photo[3] rises at ACTIVE cycle 10 -> hit at cycle 13, time 10.
    // photo[7] is held high throughout and must be ignored.
    send(4'd3);
    run_arm(3);
    photo_array[7] = 1'b1;
    expect_result(1'b1, 4'd3, 32'd10);
    repeat (10) tick();
    photo_array[3] = 1'b1;
    repeat (3) tick();
    check("t1_pre_hit_valid", result_valid, 0);
    check("t1_pre_hit_led", led, N'(1) << 3);
    tick();
    check("t1_report", fsm_state, REPORT);
    photo_array = '0;
    ack_result();

    // idx 5: 3-cycle pulse never qualifies -> miss after 100 ACTIVE cycles.
    send(4'd5);
    run_arm(5);
    expect_result(1'b0, 4'd5, 32'd100);
    repeat (2) tick();
    photo_array[5] = 1'b1;
    repeat (3) tick();
    photo_array[5] = 1'b0;
    repeat (94) tick();
    check("t2_pre_timeout", result_valid, 0);
    tick();
    check("t2_timeout_report", fsm_state, REPORT);
    ack_result();

    // idx 2: high through ARM, still high -> hit with time 0 at cycle 3.
    // Then hold the result 20 cycles with cancel asserted (ignored in REPORT).
    send(4'd2);
    photo_array[2] = 1'b1;
    run_arm(2);
    expect_result(1'b1, 4'd2, 32'd0);
    repeat (3) tick();
    check("t3_pre_hit", fsm_state, ACTIVE);
    tick();
    check("t3_report", fsm_state, REPORT);
    photo_array = '0;
    cancel = 1'b1;
    repeat (20) tick();
    cancel = 1'b0;
    check("t3_hold_report", fsm_state, REPORT);
    check("t3_hold_valid", result_valid, 1);
    ack_result();

    // idx 12 and boundary idx 10: invalid -> REPORT next cycle, led stays 0.
    expect_result(1'b0, 4'd12, 32'd0);
    send(4'd12);
    check("t4_report", fsm_state, REPORT);
    check("t4_led", led, 0);
    ack_result();
    expect_result(1'b0, 4'd10, 32'd0);
    send(4'd10);
    check("t4b_report", fsm_state, REPORT);
    ack_result();

    // idx 9: cancel at ACTIVE cycle 5 -> IDLE, no result.
    send(4'd9);
    run_arm(9);
    repeat (5) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("t5_cancel_idle", fsm_state, IDLE);
    check("t5_cancel_led", led, 0);
    check("t5_cancel_valid", result_valid, 0);

    // idx 0: ack during ARM ignored; run 7..9 broken at 10, new run from 11
    // -> hit at cycle 14 with time 11.
    send(4'd0);
    result_ack = 1'b1;
    run_arm(0);
    result_ack = 1'b0;
    expect_result(1'b1, 4'd0, 32'd11);
    repeat (7) tick();
    photo_array[0] = 1'b1;
    repeat (3) tick();
    photo_array[0] = 1'b0;
    tick();
    photo_array[0] = 1'b1;
    repeat (3) tick();
    check("t6_pre_hit", result_valid, 0);
    tick();
    check("t6_report", fsm_state, REPORT);
    photo_array = '0;
    ack_result();

    // idx 4: reset mid-ACTIVE -> IDLE, all outputs zero, no result.
    send(4'd4);
    run_arm(4);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("t7_rst_state", fsm_state, IDLE);
    check("t7_rst_led", led, 0);
    check("t7_rst_outputs", {result_valid, result_hit, result_idx, result_time}, 0);
    reset = 1'b0;
    tick();
    check("t7_ready", target_ready, 1);

    repeat (3) tick();
    check("scoreboard_drained", exp_q.size(), 0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
